// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit words from four byte reads,
// predicts the next PC (BHT for branches, static taken for JAL) and hands off to IF_ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_flag,
    input  logic [31:0] redirect_pc,
    input  logic        bp_update_flag,
    input  logic [31:0] bp_update_pc,
    input  logic        bp_update_taken,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_data,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        prediction,
    output logic        inst_valid
);

    // Handshake: a byte read is outstanding whenever mem_req=1; the arbiter
    // completes it by raising mem_grant with mem_data for mem_addr in the same
    // cycle. IF_ID takes the presented instruction on the first HOLD edge with
    // stall=0; until then pc/instruction/prediction/inst_valid stay frozen.

    localparam int         BHT_N     = 1 << BHT_IDX_W;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  k, k_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic [23:0] byte_buf, byte_buf_nx;
    logic [31:0] next_pc, next_pc_nx;
    logic [31:0] pc_nx;
    logic [31:0] instruction_nx;
    logic        prediction_nx;
    logic        inst_valid_nx;

    logic [1:0]  bht [BHT_N];

    logic [31:0]          word;
    logic [31:0]          j_imm;
    logic [31:0]          b_imm;
    logic [BHT_IDX_W-1:0] lookup_idx;
    logic [BHT_IDX_W-1:0] update_idx;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic                 unused_bits;

    // The last byte arrives on mem_data, so the word is complete combinationally.
    assign word       = {mem_data, byte_buf};
    assign j_imm      = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    assign b_imm      = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    assign lookup_idx = fetch_pc[BHT_IDX_W+1:2];
    assign update_idx = bp_update_pc[BHT_IDX_W+1:2];
    assign unused_bits = ^{bp_update_pc[31:BHT_IDX_W+2], bp_update_pc[1:0]};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = fetch_pc + 32'd4;
        if (word[6:0] == OP_JAL) begin
            pred_taken  = 1'b1;
            pred_target = fetch_pc + j_imm;
        end else if (word[6:0] == OP_BRANCH) begin
            pred_taken = bht[lookup_idx][1];
            if (pred_taken) begin
                pred_target = fetch_pc + b_imm;
            end
        end
    end

    always_comb begin
        mem_req  = rst && (state == FETCH);
        mem_addr = '0;
        if (mem_req) begin
            mem_addr = fetch_pc + {30'b0, k};
        end
    end

    always_comb begin
        state_nx       = state;
        k_nx           = k;
        fetch_pc_nx    = fetch_pc;
        byte_buf_nx    = byte_buf;
        next_pc_nx     = next_pc;
        pc_nx          = pc;
        instruction_nx = instruction;
        prediction_nx  = prediction;
        inst_valid_nx  = inst_valid;

        if (redirect_flag) begin
            // A byte granted on this edge belongs to the wrong path and is dropped.
            fetch_pc_nx    = redirect_pc;
            k_nx           = 2'd0;
            state_nx       = FETCH;
            inst_valid_nx  = 1'b0;
            instruction_nx = '0;
            prediction_nx  = 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_grant) begin
                        if (k == 2'd3) begin
                            k_nx           = 2'd0;
                            state_nx       = HOLD;
                            pc_nx          = fetch_pc;
                            instruction_nx = word;
                            prediction_nx  = pred_taken;
                            inst_valid_nx  = 1'b1;
                            next_pc_nx     = pred_target;
                        end else begin
                            k_nx = k + 2'd1;
                            unique case (k)
                                2'd0:    byte_buf_nx[7:0]   = mem_data;
                                2'd1:    byte_buf_nx[15:8]  = mem_data;
                                default: byte_buf_nx[23:16] = mem_data;
                            endcase
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_valid_nx  = 1'b0;
                        instruction_nx = '0;
                        fetch_pc_nx    = next_pc;
                        state_nx       = FETCH;
                    end
                end
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            k           <= 2'd0;
            fetch_pc    <= RESET_PC;
            byte_buf    <= '0;
            next_pc     <= '0;
            pc          <= '0;
            instruction <= '0;
            prediction  <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            state       <= state_nx;
            k           <= k_nx;
            fetch_pc    <= fetch_pc_nx;
            byte_buf    <= byte_buf_nx;
            next_pc     <= next_pc_nx;
            pc          <= pc_nx;
            instruction <= instruction_nx;
            prediction  <= prediction_nx;
            inst_valid  <= inst_valid_nx;
        end
    end

    // Saturating 2-bit counters; a lookup in the same cycle reads the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bp_update_flag) begin
            if (bp_update_taken) begin
                if (bht[update_idx] != 2'b11) begin
                    bht[update_idx] <= bht[update_idx] + 2'b01;
                end
            end else begin
                if (bht[update_idx] != 2'b00) begin
                    bht[update_idx] <= bht[update_idx] - 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory stub, instruction-level reference model
// with its own predictor table, directed scenarios then randomized traffic.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          W        = 65;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_flag = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        bp_update_flag = 1'b0;
    logic [31:0] bp_update_pc = '0;
    logic        bp_update_taken = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant = 1'b0;
    logic [7:0]  mem_data = '0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        prediction;
    logic        inst_valid;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC), .BHT_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_flag(redirect_flag), .redirect_pc(redirect_pc),
        .bp_update_flag(bp_update_flag), .bp_update_pc(bp_update_pc),
        .bp_update_taken(bp_update_taken),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant), .mem_data(mem_data),
        .pc(pc), .instruction(instruction), .prediction(prediction), .inst_valid(inst_valid)
    );

    logic [7:0]  mem_bytes [1024];
    int          bht_m [64];
    logic [31:0] m_pc, m_next, m_out_pc, m_out_inst;
    int          m_k;
    bit          m_hold, m_pred, m_valid, prev_valid;
    logic [W-1:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word32(input logic [31:0] a);
        logic [31:0] a1, a2, a3;
        a1 = a + 1; a2 = a + 2; a3 = a + 3;
        return {mem_bytes[a3[9:0]], mem_bytes[a2[9:0]], mem_bytes[a1[9:0]], mem_bytes[a[9:0]]};
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) mem_bytes[a + j] = w[8*j +: 8];
    endtask

    // Next-PC rule from the ISA encodings, computed with integer arithmetic.
    function automatic void model_predict(input logic [31:0] p, input logic [31:0] w,
                                          output bit pr, output logic [31:0] nx);
        int imm;
        pr = 1'b0;
        nx = p + 32'd4;
        if (w[6:0] == 7'b1101111) begin
            imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            if (w[31]) imm = imm - (1 << 20);
            pr = 1'b1;
            nx = p + imm;
        end else if (w[6:0] == 7'b1100011) begin
            imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
            if (w[31]) imm = imm - 4096;
            pr = (bht_m[int'(p[7:2])] >= 2);
            if (pr) nx = p + imm;
        end
    endfunction

    task automatic compare_outputs();
        logic [W-1:0] e;
        check("inst_valid", inst_valid, m_valid);
        check("instruction", instruction, m_out_inst);
        check("pc", pc, m_out_pc);
        check("prediction", prediction, m_pred);
        check("mem_req", mem_req, !m_hold);
        if (!m_hold) check("mem_addr", mem_addr, m_pc + m_k);
        if (inst_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("present_q", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("q_pred", prediction, e[64]);
                check("q_pc", pc, e[63:32]);
                check("q_inst", instruction, e[31:0]);
            end
        end
        prev_valid = inst_valid;
    endtask

    // One clock: drive at negedge, advance the model, sample at the next negedge.
    task automatic cyc(input bit g, input bit st, input bit rd, input logic [31:0] rpc,
                       input bit up, input logic [31:0] upc, input bit ut);
        logic [31:0] w, nx;
        bit pr;
        int ui;
        mem_grant = g;
        mem_data = mem_bytes[mem_addr[9:0]];
        stall = st;
        redirect_flag = rd;
        redirect_pc = rpc;
        bp_update_flag = up;
        bp_update_pc = upc;
        bp_update_taken = ut;
        if (rd) begin
            m_pc = rpc; m_k = 0; m_hold = 0; m_valid = 0; m_out_inst = '0; m_pred = 0;
        end else if (!m_hold) begin
            if (g) begin
                m_k++;
                if (m_k == 4) begin
                    w = word32(m_pc);
                    model_predict(m_pc, w, pr, nx);
                    m_out_pc = m_pc; m_out_inst = w; m_pred = pr; m_valid = 1;
                    m_next = nx; m_hold = 1; m_k = 0;
                    exp_q.push_back({pr, m_pc, w});
                end
            end
        end else if (!st) begin
            m_valid = 0; m_out_inst = '0; m_pc = m_next; m_hold = 0;
        end
        if (up) begin
            ui = int'(upc[7:2]);
            if (ut) begin
                if (bht_m[ui] < 3) bht_m[ui]++;
            end else if (bht_m[ui] > 0) begin
                bht_m[ui]--;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic do_reset(input int n, input bit g);
        rst = 1'b0;
        mem_grant = g;
        stall = 0; redirect_flag = 0; bp_update_flag = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mem_req", mem_req, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_inst_valid", inst_valid, 0);
            check("rst_instruction", instruction, 0);
            check("rst_pc", pc, 0);
            check("rst_prediction", prediction, 0);
        end
        rst = 1'b1;
        m_pc = RESET_PC; m_k = 0; m_hold = 0; m_valid = 0; m_pred = 0;
        m_out_inst = '0; m_out_pc = '0; m_next = '0; prev_valid = 0;
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        exp_q.delete();
        #1;
        check("rel_mem_req", mem_req, 1);
        check("rel_mem_addr", mem_addr, RESET_PC);
    endtask

    // Advances with grants until the model is mid-fetch at byte k.
    task automatic reach_k(input int kk);
        int budget;
        budget = 0;
        while (!(m_k == kk && !m_hold) && budget < 20) begin
            run(1);
            budget++;
        end
        check("reach_k_budget", (m_k == kk && !m_hold), 1);
    endtask

    initial begin
        logic [31:0] w;
        bit g, st, rd, up, ut;
        logic [31:0] rpc, upc;

        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[6:0] = 7'b1101111;
                1, 2: w[6:0] = 7'b1100011;
                default: ;
            endcase
            put_word(4 * i, w);
        end
        put_word(32'h00, 32'h00500513);
        put_word(32'h04, 32'h00000013);
        put_word(32'h08, 32'h0100006F);
        put_word(32'h18, 32'h00000013);
        put_word(32'h1C, 32'h00000013);
        put_word(32'h20, 32'hFE000EE3);
        put_word(32'h24, 32'h00000013);

        do_reset(2, 0);
        run(30);

        // Train the BEQ at 0x20 to strongly taken and refetch it.
        cyc(1, 0, 0, '0, 1, 32'h20, 1);
        cyc(1, 0, 0, '0, 1, 32'h20, 1);
        cyc(1, 0, 1, 32'h20, 0, '0, 0);
        run(10);
        cyc(1, 0, 0, '0, 1, 32'h20, 1);
        cyc(1, 0, 1, 32'h20, 0, '0, 0);
        run(5);
        repeat (5) cyc(1, 0, 0, '0, 1, 32'h20, 0);
        repeat (2) cyc(1, 0, 0, '0, 1, 32'h20, 1);
        cyc(1, 0, 1, 32'h20, 0, '0, 0);
        run(5);

        // Stall in HOLD for five cycles, then release.
        reach_k(3);
        run(1);
        check("stall_enter_hold", m_hold, 1);
        repeat (5) cyc(1, 1, 0, '0, 0, '0, 0);
        run(6);

        reach_k(2);
        cyc(1, 0, 1, 32'h100, 0, '0, 0);
        run(6);

        // Reset mid-fetch, then confirm counters came back as weakly not-taken.
        reach_k(2);
        do_reset(1, 1);
        cyc(1, 0, 0, '0, 1, 32'h20, 1);
        cyc(1, 0, 1, 32'h20, 0, '0, 0);
        run(5);

        for (int c = 0; c < 2000; c++) begin
            g = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 49) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                              : 32'($urandom_range(0, 255) * 4);
            up = ($urandom_range(0, 4) == 0);
            upc = $urandom_range(0, 1) ? m_pc : 32'($urandom_range(0, 255) * 4);
            ut = $urandom_range(0, 1);
            if ($urandom_range(0, 499) == 0) do_reset(1, g);
            else cyc(g, st, rd, rpc, up, upc, ut);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. It is the producer of the pc / instruction / prediction triple that the decode stage consumes through IF_ID.
- Reads each 32-bit instruction as 4 little-endian bytes over a byte-wide memory-arbiter handshake.
- Predicts the next PC using a 2-bit-counter branch history table (BHT) plus static JAL-taken.
- Accepts stall from the stall bus and redirect/BHT-update from EX.

Parameters:
RESET_PC, 32'h0, PC of the first fetch after reset.
BHT_IDX_W, 6, log2 of BHT entries; index = pc[BHT_IDX_W+1:2].

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  stall bus: IF_ID cannot accept; hold presented instruction
redirect_flag  in  1  EX mispredict/jump correction; flush and refetch
redirect_pc  in  32  corrected PC
bp_update_flag  in  1  EX resolved a conditional branch this cycle
bp_update_pc  in  32  PC of the resolved branch
bp_update_taken  in  1  actual outcome
mem_req  out  1  byte read request
mem_addr  out  32  byte address requested
mem_grant  in  1  mem_data valid for mem_addr this cycle
mem_data  in  8  returned byte
pc  out  32  PC of presented instruction
instruction  out  32  fetched instruction; 32'h0 when not valid (decoded as bubble)
prediction  out  1  1 = fetch continued at predicted-taken target
inst_valid  out  1  instruction/pc/prediction valid for IF_ID

Behaviour:
- Reset: rst is synchronous, active-low. On an edge with rst=0:
  - fetch_pc<=RESET_PC, byte counter k<=0, state<=FETCH.
  - Outputs: pc=0, instruction=0, prediction=0, inst_valid=0.
  - Every BHT counter <=2'b01.
  - While rst=0: mem_req=0, mem_addr=0.
  - Reset asserted mid-fetch discards the partial instruction.
- States:
  - FETCH: mem_req=1, mem_addr=fetch_pc+k (combinational).
    - Each edge with mem_grant=1: instruction buffer[8k+7:8k]<=mem_data, k<=k+1.
    - On the grant with k=3: k<=0, state<=HOLD. Also latch pc<=fetch_pc, instruction<=assembled word, prediction, inst_valid<=1.
    - No grant: hold; address stays stable.
  - HOLD: mem_req=0; outputs held.
    - stall=1: remain.
    - stall=0: the instruction is consumed at that edge. inst_valid<=0, instruction<=0, fetch_pc<=next_pc, state<=FETCH.
- Minimum throughput: 5 cycles/instruction (4 grant cycles + 1 HOLD cycle).
- Prediction is computed from the assembled word at the k=3 grant:
  - opcode 1101111 (JAL): prediction=1, next_pc=fetch_pc+J_imm.
  - opcode 1100011 (branch): prediction=BHT[idx][1], next_pc = prediction ? fetch_pc+B_imm : fetch_pc+4.
  - All others, including JALR: prediction=0, next_pc=fetch_pc+4.
  - J_imm/B_imm use RV32I sign-extended encodings. Additions are modulo 2^32.
- BHT update: on an edge with bp_update_flag=1, the counter at bp_update_pc index increments (taken) or decrements (not taken), saturating at 3 and 0.
  - A same-cycle lookup of the same index sees the pre-update value.
- Redirect has priority over everything except reset. On an edge with redirect_flag=1, in any state:
  - fetch_pc<=redirect_pc, k<=0, state<=FETCH.
  - inst_valid<=0, instruction<=0, prediction<=0.
  - A byte granted on that same edge is discarded.
  - stall is ignored on a redirect edge.
  - A BHT update on the same edge is still applied.
- Redirect during HOLD with stall=1 drops the held instruction.
- No alignment check; fetch_pc is used as given.

Test Plan:
- Reset then release; memory grants every cycle with bytes 13,05,50,00 at addr 0..3 -> mem_addr 0,1,2,3 on consecutive cycles; next cycle inst_valid=1, instruction=32'h00500513, pc=0, prediction=0; with stall=0 the next fetch starts at mem_addr=4.
- JAL 32'h0100006F at pc=0x8 -> prediction=1, next fetch at mem_addr=0x18; BEQ 32'hFE000EE3 at pc=0x20 with counter 01 -> prediction=0, next fetch at 0x24.
- Two bp_update_taken=1 for pc=0x20, then fetch the BEQ at 0x20 -> counter 11, prediction=1, next fetch at 0x1C (B_imm=-4). Third taken update keeps counter at 3; four not-taken updates end at 0.
- Hold stall=1 for 5 cycles in HOLD -> pc/instruction/inst_valid constant, mem_req=0; stall drops -> fetch resumes at next_pc the following cycle.
- redirect_flag=1, redirect_pc=0x100 while k=2 with mem_grant=1 -> byte discarded, inst_valid=0, instruction=0, next cycle mem_addr=0x100.
- Apply rst=0 mid-fetch at k=2 -> next cycle all outputs zero; after release, first mem_addr=RESET_PC and the BHT counters read 01.
